// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP_A = 3'd1,
    S_PREP_B = 3'd2,
    S_ITER   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  function automatic logic is_div(input op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // MUL returns the low product word, DIV/DIVU the quotient; both live in lo.
  function automatic logic returns_lo(input op_t op);
    return op inside {OP_MUL, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_special_det.sv
// Decodes operand signedness and the divide corner cases from the requested op.
module muldiv_special_det
  import muldiv_pkg::*;
(
  input  op_t             op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            div0_o,
  output logic            ovf_o,
  output logic            sa_o,
  output logic            sb_o,
  output logic            negq_o,
  output logic            negr_o
);

  always_comb begin
    sa_o   = rs1_i[XLEN-1] & (op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sb_o   = rs2_i[XLEN-1] & (op_i inside {OP_MULH, OP_DIV, OP_REM});
    div0_o = is_div(op_i) & (rs2_i == '0);
    ovf_o  = (op_i inside {OP_DIV, OP_REM}) & (rs1_i == 32'h8000_0000) & (rs2_i == '1);
    negq_o = sa_o ^ sb_o;
    negr_o = sa_o;
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer borrowing the execute-stage ALU (ADD/SUB only).
// Define MULDIV_EARLY_OUT_EN to skip straight to DONE on divide-by-zero.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            alu_sel_o,
  output logic [4:0]      alu_op_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_t          r_state, w_next;
  op_t             r_op;
  logic            r_div0, r_ovf, r_sa, r_sb, r_negq, r_negr;
  logic [XLEN-1:0] r_rs1, r_rs2, r_opa, r_opb, r_hi, r_lo, r_result;
  logic [4:0]      r_cnt;

  op_t             w_op;
  logic            w_div0, w_ovf, w_sa, w_sb, w_negq, w_negr;
  logic            w_is_div, w_carry, w_ok;
  logic [XLEN-1:0] w_s, w_final;

  assign w_op = op_t'(op_i);

  muldiv_special_det u_det (
    .op_i   (w_op),
    .rs1_i  (rs1_i),
    .rs2_i  (rs2_i),
    .div0_o (w_div0),
    .ovf_o  (w_ovf),
    .sa_o   (w_sa),
    .sb_o   (w_sb),
    .negq_o (w_negq),
    .negr_o (w_negr)
  );

  assign w_is_div = is_div(r_op);
  assign w_s      = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
  assign w_carry  = alu_result_i < r_hi;
  // hi[31] set means the true shifted remainder is 33 bits wide and exceeds |b|.
  assign w_ok     = r_hi[XLEN-1] | (w_s >= r_opb);

  always_comb begin
    if (r_div0)
      w_final = returns_lo(r_op) ? '1 : r_rs1;
    else if (r_ovf)
      w_final = (r_op == OP_DIV) ? 32'h8000_0000 : '0;
    else
      w_final = returns_lo(r_op) ? r_lo : alu_result_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy_o    = (r_state != S_IDLE);
    alu_sel_o = busy_o;
    done_o    = (r_state == S_DONE);
    alu_op_o  = ALU_ADD;
    alu_a_o   = '0;
    alu_b_o   = '0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
`ifdef MULDIV_EARLY_OUT_EN
          w_next = w_div0 ? S_DONE : S_PREP_A;
`else
          w_next = S_PREP_A;
`endif
        end
      end
      S_PREP_A: begin
        alu_op_o = r_sa ? ALU_SUB : ALU_ADD;
        alu_a_o  = r_sa ? '0 : r_rs1;
        alu_b_o  = r_sa ? r_rs1 : '0;
        w_next   = S_PREP_B;
      end
      S_PREP_B: begin
        alu_op_o = r_sb ? ALU_SUB : ALU_ADD;
        alu_a_o  = r_sb ? '0 : r_rs2;
        alu_b_o  = r_sb ? r_rs2 : '0;
        w_next   = S_ITER;
      end
      S_ITER: begin
        if (w_is_div) begin
          alu_op_o = ALU_SUB;
          alu_a_o  = w_s;
          alu_b_o  = r_opb;
        end else begin
          alu_a_o  = r_hi;
          alu_b_o  = r_lo[0] ? r_opa : '0;
        end
        if (r_cnt == 5'd31) w_next = S_FIX_LO;
      end
      S_FIX_LO: begin
        alu_op_o = r_negq ? ALU_SUB : ALU_ADD;
        alu_a_o  = r_negq ? '0 : r_lo;
        alu_b_o  = r_negq ? r_lo : '0;
        w_next   = S_FIX_HI;
      end
      S_FIX_HI: begin
        if (w_is_div) begin
          alu_op_o = r_negr ? ALU_SUB : ALU_ADD;
          alu_a_o  = r_negr ? '0 : r_hi;
          alu_b_o  = r_negr ? r_hi : '0;
        end else if (r_negq) begin
          // Two's-complement carry from the already-negated low word.
          alu_a_o  = ~r_hi;
          alu_b_o  = {{(XLEN-1){1'b0}}, (r_lo == '0)};
        end else begin
          alu_a_o  = r_hi;
        end
        w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_MUL;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_op   <= w_op;
            r_div0 <= w_div0;
            r_ovf  <= w_ovf;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_negq <= w_negq;
            r_negr <= w_negr;
            r_rs1  <= rs1_i;
            r_rs2  <= rs2_i;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_div0) r_result <= returns_lo(w_op) ? '1 : rs1_i;
`endif
          end
        end
        S_PREP_A: r_opa <= alu_result_i;
        S_PREP_B: begin
          r_opb <= alu_result_i;
          r_hi  <= '0;
          r_lo  <= w_is_div ? r_opa : alu_result_i;
          r_cnt <= '0;
        end
        S_ITER: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_is_div) begin
            r_hi <= w_ok ? alu_result_i : w_s;
            r_lo <= {r_lo[XLEN-2:0], w_ok};
          end else begin
            r_hi <= {w_carry, alu_result_i[XLEN-1:1]};
            r_lo <= {alu_result_i[0], r_lo[XLEN-1:1]};
          end
        end
        S_FIX_LO: r_lo <= alu_result_i;
        S_FIX_HI: begin
          r_hi <= alu_result_i;
          if (!flush_i) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq with a behavioural ADD/SUB ALU.
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        flush_i;
  logic        busy_o, alu_sel_o, done_o;
  logic [4:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o, alu_result_i, result_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign alu_result_i = (alu_op_o == 5'b00001) ? (alu_a_o - alu_b_o) : (alu_a_o + alu_b_o);

  muldiv_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .op_i         (op_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .alu_sel_o    (alu_sel_o),
    .alu_op_o     (alu_op_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_result_i (alu_result_i),
    .done_o       (done_o),
    .result_o     (result_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start one operation; optionally pulse a competing start at cycle 'poke'.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output logic [31:0] res, output int lat,
                        output logic busy_ok);
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = 0; busy_ok = 1'b1; res = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == poke) begin
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd2;
      end else begin
        start_i = 1'b0;
      end
      if (!busy_o || !alu_sel_o) busy_ok = 1'b0;
      if (done_o) begin
        lat = n; res = result_o;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int poke);
    logic [31:0] res;
    int          lat;
    logic        bok;
    run_op(op, a, b, poke, res, lat, bok);
    check(tag, res, exp);
    check({tag, "_lat"}, lat, 32'd37);
    check({tag, "_busy"}, {31'd0, bok}, 32'd1);
    @(negedge clk);
    check({tag, "_hold"}, result_o, exp);
    check({tag, "_idle"}, {30'd0, busy_o, done_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    rst_n = 1'b0; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",   {30'd0, busy_o, alu_sel_o}, 32'd0);
    check("rst_done",   {31'd0, done_o}, 32'd0);
    check("rst_aluop",  {27'd0, alu_op_o}, 32'd0);
    check("rst_alua",   alu_a_o, 32'd0);
    check("rst_alub",   alu_b_o, 32'd0);
    check("rst_result", result_o, 32'd0);
    rst_n = 1'b1;

    do_op("mul_7x6",      3'd0, 32'd7,        32'd6,        32'd42,         0);
    do_op("mulhu_ff",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   0);
    do_op("mul_ff",       3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   0);
    do_op("mulh_m1",      3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,   0);
    do_op("mulhsu_m1x2",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF,   0);
    do_op("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,   0);
    do_op("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,   0);
    do_op("divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,         0);
    do_op("remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,          0);
    do_op("divu_5_0",     3'd5, 32'd5,        32'd0,        32'hFFFFFFFF,   0);
    do_op("remu_5_0",     3'd7, 32'd5,        32'd0,        32'd5,          0);
    do_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   0);
    do_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,   0);

    // Flush while ITER counter is 10 (cycle 13 after acceptance).
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd5;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (13) @(negedge clk);
    check("flush_pre_busy", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen_done = 1'b1;
    end
    check("flush_nodone", {31'd0, seen_done}, 32'd0);
    do_op("mul_3x3", 3'd0, 32'd3, 32'd3, 32'd9, 0);

    // Start pulsed while busy must not disturb the running divide.
    do_op("divu_poke", 3'd5, 32'd100, 32'd7, 32'd14, 5);

    // Asynchronous reset in the middle of ITER.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd3; rs1_i = 32'hFFFFFFFF; rs2_i = 32'hFFFFFFFF;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_busy", {31'd0, busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",   {30'd0, busy_o, alu_sel_o}, 32'd0);
    check("arst_done",   {31'd0, done_o}, 32'd0);
    check("arst_aluop",  {27'd0, alu_op_o}, 32'd0);
    check("arst_alua",   alu_a_o, 32'd0);
    check("arst_alub",   alu_b_o, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("mul_after_rst", 3'd0, 32'd12, 32'd11, 32'd132, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
